pipe_adder: RTL

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
//   Carry-chunked pipelined adder with a valid/ready handshake on each side.
//   The WIDTH-bit addition a + b + cin is split into STAGES = WIDTH/CHUNK
//   chunks. Stage k adds chunk k using the carry registered by stage k-1.
//   Stage 0 uses cin instead. Each stage passes three things to the next
//   stage unchanged: the sum chunks already computed, the operand chunks not
//   yet added, and its valid bit.
//
//   Each stage has its own valid bit. A stage may load when it is empty or when
//   everything downstream of it can move this cycle. As a result, a full
//   pipeline can accept one input and deliver one output in the same cycle.
//
// Parameters
//   WIDTH  operand/sum width in bits (default 32)
//   CHUNK  bits added per pipeline stage (default 8); WIDTH % CHUNK must be 0
//
// Ports
//   clk        single clock, all state on the rising edge
//   resetn     asynchronous active-low reset; clears every stage
//   in_valid   a, b, cin valid this cycle
//   in_ready   block accepts input this cycle (never depends on in_valid)
//   a, b       unsigned operands
//   cin        carry-in
//   out_valid  sum/cout valid
//   out_ready  downstream accepts the result
//   sum        (a + b + cin) mod 2^WIDTH
//   cout       carry-out of the full WIDTH-bit addition
//   ovf        (only with PIPE_ADDER_OVF_EN defined) signed overflow,
//              computed as carry into the MSB XOR cout
//
// Configuration macro
//   PIPE_ADDER_OVF_EN  adds the registered ovf output
// -----------------------------------------------------------------------------
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Guarded so that a bad configuration reaches the elaboration check below
  // instead of failing first on a division by zero or a zero-sized array.
  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int STAGES     = (WIDTH / CHUNK_SAFE < 1) ? 1 : (WIDTH / CHUNK_SAFE);
  localparam int LAST       = STAGES - 1;

  generate
    if (CHUNK < 1 || WIDTH < CHUNK_SAFE || (WIDTH % CHUNK_SAFE) != 0) begin : g_bad_cfg
      $error("pipe_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
             WIDTH, CHUNK);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage registers. Index k holds the state captured by stage k.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] sum_q;
  logic [STAGES-1:0]            carry_q;

  // ---------------------------------------------------------------------------
  // Inputs seen by each stage, plus the values each stage would load.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0]            ready;
  logic [STAGES-1:0]            src_valid;
  logic [STAGES-1:0][WIDTH-1:0] src_a;
  logic [STAGES-1:0][WIDTH-1:0] src_b;
  logic [STAGES-1:0][WIDTH-1:0] src_sum;
  logic [STAGES-1:0]            src_carry;
  logic [STAGES-1:0][WIDTH-1:0] nxt_sum;
  logic [STAGES-1:0]            nxt_carry;
  logic [CHUNK:0]               part;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through this
    // block leaves one unassigned and no latch is inferred.
    ready     = '0;
    src_valid = '0;
    src_a     = '0;
    src_b     = '0;
    src_sum   = '0;
    src_carry = '0;
    nxt_sum   = '0;
    nxt_carry = '0;
    part      = '0;

    // ready_k = !valid_k || ready_{k+1}. This is unrolled into "out_ready, or
    // any stage from k to the output is empty", so the chain is built from
    // register state and out_ready only, never from in_valid.
    for (int k = 0; k < STAGES; k++) begin
      ready[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!valid_q[j]) ready[k] = 1'b1;
      end
    end

    // Stage 0 is fed from the ports. Every other stage is fed from the
    // stage before it.
    src_valid[0] = in_valid;
    src_a[0]     = a;
    src_b[0]     = b;
    src_sum[0]   = '0;
    src_carry[0] = cin;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_sum[k]   = sum_q[k-1];
      src_carry[k] = carry_q[k-1];
    end

    // Stage k adds only chunk k. Lower sum chunks pass through unchanged.
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
           + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, src_carry[k]};
      nxt_sum[k]                  = src_sum[k];
      nxt_sum[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      nxt_carry[k]                = part[CHUNK];
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  // The MSB belongs to the last chunk. The carry into the MSB is recovered as
  // a ^ b ^ sum at that bit, and XOR with the chunk carry-out gives signed
  // overflow.
  logic nxt_ovf;
  logic ovf_q;
  assign nxt_ovf = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1]
                 ^ nxt_sum[LAST][WIDTH-1] ^ nxt_carry[LAST];
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the datapath registers are reset along with the valid bits,
      // because sum/cout are required to read zero while in reset.
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
`ifdef PIPE_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every stage samples the values
      // its upstream neighbour held before this edge.
      for (int k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= src_valid[k];
          // Data is captured only with a real transaction. Otherwise the last
          // result stays visible after it has been consumed.
          if (src_valid[k]) begin
            a_q[k]     <= src_a[k];
            b_q[k]     <= src_b[k];
            sum_q[k]   <= nxt_sum[k];
            carry_q[k] <= nxt_carry[k];
          end
        end
      end
`ifdef PIPE_ADDER_OVF_EN
      if (ready[LAST] && src_valid[LAST]) ovf_q <= nxt_ovf;
`endif
    end
  end

  // The last stage's operand copies have no consumer. Synthesis trims them.
  logic unused_ops;
  assign unused_ops = ^{a_q[LAST], b_q[LAST]};

  assign in_ready  = ready[0];
  assign out_valid = valid_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = carry_q[LAST];
`ifdef PIPE_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
